// File: rtl/fifo_access_scheduler.sv
// fifo_access_scheduler: round-robin write arbiter plus read scheduler that
// owns the single access port of a Synchronous_FIFO. Writes and reads share
// the FIFO's one-op-per-cycle budget; contested cycles alternate W/R.

// Per-producer lane: flags a request that lies at or above the round-robin
// pointer, so the top level can pick "first at/after rr_ptr" with a
// double-mask priority search instead of a modular scan.
module fifo_sched_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [IW-1:0] rr_ptr,
  input  logic          vld,
  output logic          hi_req
);
  localparam logic [IW-1:0] LID = IW'(LANE);

  // Request belongs to the upper (not-yet-wrapped) half of the search.
  always_comb hi_req = vld && (LID >= rr_ptr);
endmodule

module fifo_access_scheduler #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       rd_req,
  output logic                       rd_ack,
  output logic                       rd_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic                       fifo_w_in,
  output logic                       fifo_r_in,
  output logic [WIDTH-1:0]           fifo_data_in
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0]      rr_ptr;
  logic               wr_turn;
  logic [NUM_REQ-1:0] hi_req;
  logic               hi_any;
  logic [IW-1:0]      win;
  logic               wr_cand, rd_cand;
  logic               do_wr, do_rd;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      fifo_sched_lane #(.IW(IW), .LANE(g)) u_lane (
        .rr_ptr (rr_ptr),
        .vld    (req_valid[g]),
        .hi_req (hi_req[g])
      );
    end
  endgenerate

  // Round-robin winner: lowest requester at/after rr_ptr, else wrap to the
  // lowest requester overall. Scanning downward lets the lowest index win.
  always_comb begin
    hi_any = |hi_req;
    win    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi_any ? hi_req[i] : req_valid[i]) win = IW'(i);
    end
  end

  // Operation select; every strobe is masked while reset is held so the
  // FIFO sees nothing from the instant rst drops.
  always_comb begin
    wr_cand = (|req_valid) && !fifo_full;
    rd_cand = rd_req && !fifo_empty;
    do_wr   = rst && wr_cand && (!rd_cand || wr_turn);
    do_rd   = rst && rd_cand && (!wr_cand || !wr_turn);
  end

  // Drive the grant, ack and FIFO port from the selected operation.
  always_comb begin
    req_ready    = '0;
    grant_id     = '0;
    fifo_data_in = '0;
    fifo_w_in    = do_wr;
    fifo_r_in    = do_rd;
    rd_ack       = do_rd;
    if (do_wr) begin
      grant_id     = win;
      fifo_data_in = req_data[win*WIDTH +: WIDTH];
      for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (win == IW'(i));
    end
  end

  // State: pointer advances past each winner, turn flips only on contested
  // cycles, rd_valid marks the cycle the popped word appears on data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wr_turn  <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (wr_cand && rd_cand) wr_turn <= ~wr_turn;
      if (do_wr) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
    end
  end
endmodule
